// File: rtl/cga_intr_levres.sv
// Priority-interrupt level resolver: PID register, highest-enabled-level pick, REQ/ACK handshake to microcode.
// Latency: a set pulse sampled on one edge raises LVREQN on the next edge when PIE and CURLEV allow it.
// Backpressure: NEWLEV stays frozen until LVACKN; an unanswered request is dropped after ACK_TIMEOUT cycles.
module cga_intr_levres #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter logic [15:0] CLR_MASK    = 16'h0000
) (
    input  logic        MCLK,
    input  logic        RESETN,
    input  logic [15:0] PIDSET,
    input  logic [15:0] FIDB,
    input  logic        LDPIDN,
    input  logic [15:0] PIE,
    input  logic [3:0]  CURLEV,
    input  logic        LVACKN,
    output logic        LVREQN,
    output logic [3:0]  NEWLEV,
    output logic [15:0] PIDRD,
    output logic        TOERR
);

    localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;

    state_t        state;
    logic [15:0]   pid;
    logic [CW-1:0] ackCnt;
    logic [CW-1:0] cntInc;
    logic [15:0]   act;
    logic [15:0]   ackClr;
    logic [3:0]    hiLev;
    logic          pend;
    logic          timeout;

    always_comb begin
        act   = pid & PIE;
        hiLev = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (act[i]) hiLev = 4'(i);
        end
        // Level 0 can never exceed CURLEV, so it never requests.
        pend    = (act != 16'h0000) && (hiLev > CURLEV);
        cntInc  = (ackCnt == CW'(ACK_TIMEOUT)) ? ackCnt : ackCnt + CW'(1);
        timeout = (cntInc >= CW'(ACK_TIMEOUT));
        ackClr  = 16'h0000;
        if (state == REQ && !LVACKN && CLR_MASK[NEWLEV]) ackClr = 16'h0001 << NEWLEV;
    end

    assign PIDRD = pid;

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            pid    <= 16'h0000;
            state  <= IDLE;
            LVREQN <= 1'b1;
            NEWLEV <= 4'd0;
            TOERR  <= 1'b0;
            ackCnt <= '0;
        end else begin
            // Set pulses are ORed last so they beat both a load and an ack clear.
            pid   <= ((LDPIDN ? pid : FIDB) & ~ackClr) | PIDSET;
            TOERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend) begin
                        state  <= REQ;
                        LVREQN <= 1'b0;
                        NEWLEV <= hiLev;
                        ackCnt <= '0;
                    end
                end
                REQ: begin
                    if (!LVACKN) begin
                        state  <= ACKD;
                        LVREQN <= 1'b1;
                    end else begin
                        ackCnt <= cntInc;
                        if (timeout) begin
                            state  <= IDLE;
                            LVREQN <= 1'b1;
                            TOERR  <= 1'b1;
                        end
                    end
                end
                ACKD: begin
                    if (LVACKN) state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    LVREQN <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cga_intr_levres.sv
// Bench for cga_intr_levres: directed scenarios then randomized traffic against a behavioural model.
module tb_cga_intr_levres;

    localparam logic [15:0] MASK = 16'h4000;
    localparam int TMO = 15;

    logic        MCLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [15:0] PIDSET = '0, FIDB = '0, PIE = '0;
    logic        LDPIDN = 1'b1, LVACKN = 1'b1;
    logic [3:0]  CURLEV = '0;
    logic        LVREQN, TOERR, lvreqn0, toerr0;
    logic [3:0]  NEWLEV, newlev0;
    logic [15:0] PIDRD, pidrd0;

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 = no request, 1 = requesting, 2 = acknowledged, waiting for release.
    logic [15:0] mPid = '0;
    int          phase = 0;
    int          mLev = 0;
    int          age = 0;
    bit          mTo = 0;

    always #5 MCLK = ~MCLK;

    cga_intr_levres #(.ACK_TIMEOUT(TMO), .CLR_MASK(MASK)) dut (
        .MCLK(MCLK), .RESETN(RESETN), .PIDSET(PIDSET), .FIDB(FIDB), .LDPIDN(LDPIDN),
        .PIE(PIE), .CURLEV(CURLEV), .LVACKN(LVACKN), .LVREQN(LVREQN), .NEWLEV(NEWLEV),
        .PIDRD(PIDRD), .TOERR(TOERR));

    cga_intr_levres #(.ACK_TIMEOUT(TMO)) dut0 (
        .MCLK(MCLK), .RESETN(RESETN), .PIDSET(PIDSET), .FIDB(FIDB), .LDPIDN(LDPIDN),
        .PIE(PIE), .CURLEV(CURLEV), .LVACKN(LVACKN), .LVREQN(lvreqn0), .NEWLEV(newlev0),
        .PIDRD(pidrd0), .TOERR(toerr0));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int highest(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic modelEdge();
        int hi;
        logic [15:0] base;
        logic [15:0] clr;
        hi   = highest(mPid & PIE);
        clr  = '0;
        mTo  = 0;
        if (phase == 0) begin
            if (hi > int'(CURLEV)) begin
                phase = 1; mLev = hi; age = 0;
            end
        end else if (phase == 1) begin
            if (!LVACKN) begin
                phase = 2;
                if (MASK[mLev]) clr[mLev] = 1'b1;
            end else begin
                age = age + 1;
                if (age >= TMO) begin
                    phase = 0; mTo = 1;
                end
            end
        end else if (LVACKN) begin
            phase = 0;
        end
        base = LDPIDN ? mPid : FIDB;
        mPid = (base & ~clr) | PIDSET;
    endtask

    task automatic compareAll();
        chk("lvreqn", {15'b0, LVREQN}, {15'b0, phase != 1});
        chk("newlev", {12'b0, NEWLEV}, 16'(mLev));
        chk("pidrd", PIDRD, mPid);
        chk("toerr", {15'b0, TOERR}, {15'b0, mTo});
    endtask

    task automatic step();
        @(posedge MCLK);
        modelEdge();
        #1;
        compareAll();
    endtask

    // Called 1 time unit after an edge; asserts reset mid-cycle and releases it before the next edge.
    task automatic pulseReset();
        #2 RESETN = 1'b0;
        mPid = '0; phase = 0; mLev = 0; age = 0; mTo = 0;
        #1;
        chk("rst_lvreqn", {15'b0, LVREQN}, 16'h0001);
        chk("rst_pidrd", PIDRD, 16'h0000);
        chk("rst_newlev", {12'b0, NEWLEV}, 16'h0000);
        chk("rst_toerr", {15'b0, TOERR}, 16'h0000);
        #2 RESETN = 1'b1;
    endtask

    task automatic clearPid();
        LDPIDN = 1'b0; FIDB = 16'h0000;
        step();
        LDPIDN = 1'b1;
    endtask

    initial begin
        #12;
        chk("reset_lvreqn", {15'b0, LVREQN}, 16'h0001);
        chk("reset_pidrd", PIDRD, 16'h0000);
        chk("reset_newlev", {12'b0, NEWLEV}, 16'h0000);
        chk("reset_toerr", {15'b0, TOERR}, 16'h0000);
        PIDSET = 16'h0100;
        #2 RESETN = 1'b1;
        step();
        chk("first_edge_pid", PIDRD, 16'h0100);
        PIDSET = 16'h0000;
        clearPid();

        // Basic request/ack on level 13.
        PIE = 16'hFFFF; CURLEV = 4'd3; PIDSET = 16'h2000;
        step();
        PIDSET = 16'h0000;
        chk("l13_not_yet", {15'b0, LVREQN}, 16'h0001);
        step();
        chk("l13_req", {15'b0, LVREQN}, 16'h0000);
        chk("l13_newlev", {12'b0, NEWLEV}, 16'd13);
        LVACKN = 1'b0;
        step();
        chk("l13_ack", {15'b0, LVREQN}, 16'h0001);
        CURLEV = 4'd15; LVACKN = 1'b1;
        step();
        clearPid();

        // Only the highest enabled level counts.
        CURLEV = 4'd11; PIDSET = 16'h0802;
        step();
        PIDSET = 16'h0000;
        step(); step();
        chk("l11_blocked", {15'b0, LVREQN}, 16'h0001);
        CURLEV = 4'd0;
        step();
        chk("l11_req", {15'b0, LVREQN}, 16'h0000);
        chk("l11_newlev", {12'b0, NEWLEV}, 16'd11);
        LVACKN = 1'b0; step();
        CURLEV = 4'd15; LVACKN = 1'b1; step();
        clearPid();

        // Ack clear honours CLR_MASK.
        CURLEV = 4'd0; PIDSET = 16'h4000;
        step();
        PIDSET = 16'h0000;
        step();
        LVACKN = 1'b0; step();
        chk("clr_mask_bit14", {15'b0, PIDRD[14]}, 16'h0000);
        chk("no_mask_bit14", {15'b0, pidrd0[14]}, 16'h0001);
        CURLEV = 4'd15; LVACKN = 1'b1; step();
        clearPid();

        // Set pulse on the ack edge beats the clear.
        CURLEV = 4'd0; PIDSET = 16'h4000;
        step();
        PIDSET = 16'h0000;
        step();
        LVACKN = 1'b0; PIDSET = 16'h4000; step();
        chk("set_beats_clr", {15'b0, PIDRD[14]}, 16'h0001);
        PIDSET = 16'h0000; CURLEV = 4'd15; LVACKN = 1'b1; step();
        clearPid();

        // Timeout after TMO cycles in request, then re-request.
        CURLEV = 4'd0; PIDSET = 16'h0020;
        step();
        PIDSET = 16'h0000;
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        chk("pre_timeout", {15'b0, TOERR}, 16'h0000);
        step();
        chk("timeout_pulse", {15'b0, TOERR}, 16'h0001);
        chk("timeout_drop", {15'b0, LVREQN}, 16'h0001);
        step();
        chk("timeout_once", {15'b0, TOERR}, 16'h0000);
        chk("rerequest", {15'b0, LVREQN}, 16'h0000);
        LVACKN = 1'b0; step();
        CURLEV = 4'd15; LVACKN = 1'b1; step();
        clearPid();

        // NEWLEV frozen during request.
        CURLEV = 4'd0; PIDSET = 16'h0020;
        step();
        PIDSET = 16'h0000;
        step();
        PIDSET = 16'h1000; step();
        PIDSET = 16'h0000; step();
        chk("frozen_newlev", {12'b0, NEWLEV}, 16'd5);
        LVACKN = 1'b0; step();
        CURLEV = 4'd5; LVACKN = 1'b1; step();
        step();
        chk("next_newlev", {12'b0, NEWLEV}, 16'd12);
        chk("next_req", {15'b0, LVREQN}, 16'h0000);
        LVACKN = 1'b0; step();
        CURLEV = 4'd15; LVACKN = 1'b1; step();
        clearPid();

        // Load with simultaneous set, then reset in the middle of a request.
        LDPIDN = 1'b0; FIDB = 16'h00F0; PIDSET = 16'h0001;
        step();
        chk("load_and_set", PIDRD, 16'h00F1);
        LDPIDN = 1'b1; PIDSET = 16'h0000; CURLEV = 4'd0;
        step();
        chk("req_before_rst", {15'b0, LVREQN}, 16'h0000);
        pulseReset();
        step();
        chk("no_toerr_after_rst", {15'b0, TOERR}, 16'h0000);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            PIDSET = ($urandom_range(0, 5) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000;
            if ($urandom_range(0, 40) == 0) PIDSET = 16'($urandom);
            LDPIDN = ($urandom_range(0, 30) != 0);
            FIDB   = 16'($urandom);
            if ($urandom_range(0, 20) == 0) PIE = 16'($urandom);
            if ($urandom_range(0, 10) == 0) CURLEV = 4'($urandom);
            LVACKN = ($urandom_range(0, 9) > 2);
            if ($urandom_range(0, 400) == 0) pulseReset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
